// File: rtl/morra_pkg.sv
// Shared types for the morra (rock-paper-scissors) match engine.
//   move_t  : player move encoding (00 invalid, 01 sasso, 10 carta, 11 forbice)
//   res_t   : round / match result encoding (00 none, 01 P1, 10 P2, 11 draw)
//   state_t : match controller states
package morra_pkg;

   typedef enum logic [1:0] {
      MV_NONE    = 2'b00,
      MV_SASSO   = 2'b01,
      MV_CARTA   = 2'b10,
      MV_FORBICE = 2'b11
   } move_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_P1   = 2'b01,
      RES_P2   = 2'b10,
      RES_DRAW = 2'b11
   } res_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/morra_round_judge.sv
// Combinational round judge.
// Ports:
//   a   in  move_t  player-1 move
//   b   in  move_t  player-2 move
//   res out res_t   RES_NONE if either move is invalid, else winner or draw
// Sasso beats forbice, forbice beats carta, carta beats sasso.
module morra_round_judge
   import morra_pkg::*;
(
   input  move_t a,
   input  move_t b,
   output res_t  res
);

   logic a_wins;

   always_comb begin
      a_wins = ((a == MV_SASSO)   && (b == MV_FORBICE)) ||
               ((a == MV_FORBICE) && (b == MV_CARTA))   ||
               ((a == MV_CARTA)   && (b == MV_SASSO));
      res = RES_NONE;
      if ((a == MV_NONE) || (b == MV_NONE))
         res = RES_NONE;
      else if (a == b)
         res = RES_DRAW;
      else if (a_wins)
         res = RES_P1;
      else
         res = RES_P2;
   end

endmodule

// File: rtl/morra_match_fsmd.sv
// Morra match engine: judges rounds, keeps scores and round count, declares the
// match winner. Match length is MIN_ROUNDS + setup value; the match ends early
// once MIN_ROUNDS have been played and one player leads by WIN_LEAD.
// Ports:
//   clk           in   clock, rising edge
//   RST           in   asynchronous reset, active high
//   INIZIO_SETUP  in   load configuration from {SECONDO,PRIMO}, start a match
//   INIZIO_CONTO  in   PRIMO/SECONDO carry moves this cycle
//   PRIMO         in   player-1 move (setup: low setup bits)
//   SECONDO       in   player-2 move (setup: high setup bits)
//   MANCHE        out  registered round result
//   PARTITA       out  registered match result (00 while in progress)
//   ROUNDS_PLAYED out  valid rounds counted in the current match
// Build option: MORRA_NO_REPEAT_EN enables the no-repeat rule (the winner of
// the previous counted round may not reuse the winning move).
//
// state   | meaning
// ST_IDLE | after reset, waiting for a setup
// ST_PLAY | match running, rounds are judged and counted
// ST_DONE | match decided, results held until the next setup
module morra_match_fsmd
   import morra_pkg::*;
#(
   parameter int MIN_ROUNDS = 4,
   parameter int SETUP_W    = 4,
   parameter int CNT_W      = 5,
   parameter int WIN_LEAD   = 2
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             INIZIO_SETUP,
   input  logic             INIZIO_CONTO,
   input  logic [1:0]       PRIMO,
   input  logic [1:0]       SECONDO,
   output logic [1:0]       MANCHE,
   output logic [1:0]       PARTITA,
   output logic [CNT_W-1:0] ROUNDS_PLAYED
);

   state_t           state, state_n;
   res_t             manche, manche_n;
   res_t             partita, partita_n;
   logic [CNT_W-1:0] played, played_n;
   logic [CNT_W-1:0] s1, s1_n;
   logic [CNT_W-1:0] s2, s2_n;
   logic [CNT_W-1:0] max_rounds, max_rounds_n;
   logic [SETUP_W-1:0] setup_val;
   logic             violation;
   logic             lead_ok;
   res_t             res;
   move_t            mv1, mv2;

   assign mv1       = move_t'(PRIMO);
   assign mv2       = move_t'(SECONDO);
   assign setup_val = SETUP_W'({SECONDO, PRIMO});

   morra_round_judge u_judge (
      .a   (mv1),
      .b   (mv2),
      .res (res)
   );

`ifdef MORRA_NO_REPEAT_EN
   // Last counted winner and the move that won; RES_NONE means no restriction.
   res_t  lw_who, lw_who_n;
   move_t lw_move, lw_move_n;

   assign violation = ((lw_who == RES_P1) && (mv1 == lw_move)) ||
                      ((lw_who == RES_P2) && (mv2 == lw_move));

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         lw_who  <= RES_NONE;
         lw_move <= MV_NONE;
      end else begin
         lw_who  <= lw_who_n;
         lw_move <= lw_move_n;
      end
   end
`else
   assign violation = 1'b0;
`endif

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         manche     <= RES_NONE;
         partita    <= RES_NONE;
         played     <= '0;
         s1         <= '0;
         s2         <= '0;
         max_rounds <= '0;
      end else begin
         state      <= state_n;
         manche     <= manche_n;
         partita    <= partita_n;
         played     <= played_n;
         s1         <= s1_n;
         s2         <= s2_n;
         max_rounds <= max_rounds_n;
      end
   end

   always_comb begin
      state_n      = state;
      manche_n     = RES_NONE;
      partita_n    = partita;
      played_n     = played;
      s1_n         = s1;
      s2_n         = s2;
      max_rounds_n = max_rounds;
      lead_ok      = 1'b0;
`ifdef MORRA_NO_REPEAT_EN
      lw_who_n     = lw_who;
      lw_move_n    = lw_move;
`endif

      if (INIZIO_SETUP) begin
         played_n     = '0;
         s1_n         = '0;
         s2_n         = '0;
         max_rounds_n = CNT_W'(MIN_ROUNDS) + CNT_W'(setup_val);
         partita_n    = RES_NONE;
         state_n      = ST_PLAY;
`ifdef MORRA_NO_REPEAT_EN
         lw_who_n     = RES_NONE;
         lw_move_n    = MV_NONE;
`endif
      end else if ((state == ST_PLAY) && INIZIO_CONTO &&
                   (res != RES_NONE) && !violation) begin
         manche_n = res;
         played_n = played + 1'b1;
         if (res == RES_P1) s1_n = s1 + 1'b1;
         if (res == RES_P2) s2_n = s2 + 1'b1;
`ifdef MORRA_NO_REPEAT_EN
         lw_who_n  = (res == RES_DRAW) ? RES_NONE : res;
         lw_move_n = (res == RES_P1) ? mv1 : (res == RES_P2) ? mv2 : MV_NONE;
`endif
         // End check uses this round's updated counts.
         lead_ok = (s1_n >= s2_n) ? ((s1_n - s2_n) >= CNT_W'(WIN_LEAD))
                                  : ((s2_n - s1_n) >= CNT_W'(WIN_LEAD));
         if (((played_n >= CNT_W'(MIN_ROUNDS)) && lead_ok) ||
             (played_n == max_rounds)) begin
            if (s1_n > s2_n)      partita_n = RES_P1;
            else if (s2_n > s1_n) partita_n = RES_P2;
            else                  partita_n = RES_DRAW;
            state_n = ST_DONE;
         end
      end
   end

   assign MANCHE        = manche;
   assign PARTITA       = partita;
   assign ROUNDS_PLAYED = played;

endmodule
